// File: rtl/barrelshift_pkg.sv
// barrelshift_pkg: shared widths, rotate helpers and the pipeline word type
package barrelshift_pkg;

    localparam int N = 8;
    localparam int M = 3;

    typedef struct packed {
        logic [N-1:0] data;
        logic [M-1:0] num;
        logic         lr;
    } rot_word_t;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] data, input logic [M-1:0] amt);
        logic [2*N-1:0] t;
        t = {data, data} << amt;
        return t[2*N-1:N];
    endfunction

    function automatic logic [N-1:0] rotr(input logic [N-1:0] data, input logic [M-1:0] amt);
        logic [2*N-1:0] t;
        t = {data, data} >> amt;
        return t[N-1:0];
    endfunction

endpackage

// File: rtl/barrel_unrotate_pipe_if.sv
// barrel_unrotate_pipe_if: upstream and downstream valid/ready word bus
interface barrel_unrotate_pipe_if #(
    parameter int N = barrelshift_pkg::N,
    parameter int M = barrelshift_pkg::M
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] In;
    logic [M-1:0] Num;
    logic         LR;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] Out;
    logic         out_lr;

    modport master (
        output in_valid, In, Num, LR, out_ready,
        input  in_ready, out_valid, Out, out_lr
    );

    modport slave (
        input  in_valid, In, Num, LR, out_ready,
        output in_ready, out_valid, Out, out_lr
    );
endinterface

// File: rtl/rotate_stage.sv
// rotate_stage: one pipeline slot undoing the 2^K part of the original rotation
module rotate_stage
    import barrelshift_pkg::rot_word_t;
    import barrelshift_pkg::rotl;
    import barrelshift_pkg::rotr;
#(
    parameter int N = barrelshift_pkg::N,
    parameter int M = barrelshift_pkg::M,
    parameter int K = 0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  logic      in_valid,
    input  rot_word_t in_word,
    output logic      out_valid,
    output rot_word_t out_word
);
    localparam logic [M-1:0] step = M'(1 << K);

    logic [N-1:0] rot;

    // rotate opposite to the original direction when this bit of num is set
    always_comb rot = !in_word.num[K] ? in_word.data : in_word.lr ? rotr(in_word.data, step) : rotl(in_word.data, step);

    // take the upstream word (or a bubble) whenever the slot is empty or its word moves on
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_word  <= '0;
        end else if (en) begin
            out_valid <= in_valid;
            if (in_valid) out_word <= '{data: rot, num: in_word.num, lr: in_word.lr};
        end
endmodule

// File: rtl/barrel_unrotate_pipe.sv
// barrel_unrotate_pipe: M-stage log-shifter pipeline restoring a rotated word
module barrel_unrotate_pipe
    import barrelshift_pkg::rot_word_t;
#(
    parameter int N = barrelshift_pkg::N,
    parameter int M = barrelshift_pkg::M
) (
    input  logic                   clk,
    input  logic                   rst_n,
    barrel_unrotate_pipe_if.slave  bus,
    output logic                   busy
);
    logic [M:0]   v;
    logic [M-1:0] en;
    rot_word_t    w [M+1];
    logic [M-1:0] unused_num;

    assign v[0] = bus.in_valid;
    assign w[0] = '{data: bus.In, num: bus.Num, lr: bus.LR};

    for (genvar k = 0; k < M; k++) begin : g_stage
        // a slot can load unless it and every slot after it are full and the output is stalled
        assign en[k] = bus.out_ready | ~&v[M:k+1];
        rotate_stage #(.N(N), .M(M), .K(k)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en[k]),
            .in_valid (v[k]),
            .in_word  (w[k]),
            .out_valid(v[k+1]),
            .out_word (w[k+1])
        );
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = v[M];
    assign bus.Out       = w[M].data;
    assign bus.out_lr    = w[M].lr;
    assign busy          = |v[M:1];
    assign unused_num    = w[M].num;
endmodule

// File: tb/tb_barrel_unrotate_pipe.sv
// tb_barrel_unrotate_pipe: directed and randomised checks of the unrotate pipeline
module tb_barrel_unrotate_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int total = 0;
    int passed = 0;
    int failed = 0;
    int n_out = 0;
    logic [7:0] exp_q[$];
    logic lr_q[$];

    barrel_unrotate_pipe_if bus ();

    barrel_unrotate_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));

    always #5 clk = ~clk;

    function automatic logic [7:0] fwd(input logic [7:0] x, input logic [2:0] n, input logic l);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++)
            if (l) y[(i + int'(n)) % 8] = x[i];
            else y[(i + 8 - int'(n)) % 8] = x[i];
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic vi, input logic [7:0] din, input logic [2:0] n, input logic l,
                       input logic [7:0] x, input logic ordy, output logic acc);
        bus.in_valid = vi;
        bus.In = din;
        bus.Num = n;
        bus.LR = l;
        bus.out_ready = ordy;
        #1;
        acc = vi && bus.in_ready;
        if (bus.out_valid && ordy) begin
            if (exp_q.size() == 0) chk("spurious", 32'(bus.out_valid), 0);
            else begin
                chk("data", 32'(bus.Out), 32'(exp_q.pop_front()));
                chk("lr", 32'(bus.out_lr), 32'(lr_q.pop_front()));
            end
            n_out++;
        end
        if (acc) begin
            exp_q.push_back(x);
            lr_q.push_back(l);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [7:0] din, input logic [2:0] n, input logic l, input logic [7:0] x);
        int cnt;
        int base;
        logic acc;
        base = n_out;
        cyc(1'b1, din, n, l, x, 1'b1, acc);
        chk("one_accept", 32'(acc), 1);
        cnt = 0;
        while (n_out == base && cnt < 10) begin
            cnt++;
            cyc(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b1, acc);
        end
        chk("one_latency", cnt, 3);
        chk("one_busy_after", 32'(busy), 0);
    endtask

    initial begin
        logic acc;
        logic [7:0] x;
        logic [2:0] n;
        logic l;
        int base;
        int k;
        int first;
        int last;
        int prev;
        bit did_rst;
        bus.in_valid = 1'b0;
        bus.In = '0;
        bus.Num = '0;
        bus.LR = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_out", 32'(bus.Out), 0);
        chk("rst_out_lr", 32'(bus.out_lr), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_in_ready", 32'(bus.in_ready), 1);
        chk("idle_out_valid", 32'(bus.out_valid), 0);
        chk("idle_busy", 32'(busy), 0);
        one(8'hD2, 3'd3, 1'b0, 8'h96);
        one(8'h2D, 3'd1, 1'b1, 8'h96);
        one(8'hA5, 3'd0, 1'b0, 8'hA5);
        one(8'hA5, 3'd0, 1'b1, 8'hA5);
        one(8'h01, 3'd7, 1'b1, 8'h02);
        base = n_out;
        first = -1;
        last = -1;
        for (int i = 0; i < 12; i++) begin
            prev = n_out;
            if (i < 8) begin
                x = 8'(i * 37 + 5);
                n = 3'(i);
                l = 1'(i);
                cyc(1'b1, fwd(x, n, l), n, l, x, 1'b1, acc);
                chk("stream_accept", 32'(acc), 1);
            end else cyc(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b1, acc);
            if (n_out != prev) begin
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("stream_count", n_out - base, 8);
        chk("stream_span", last - first, 7);
        base = n_out;
        k = 0;
        for (int i = 0; i < 6; i++) begin
            x = 8'hC3 ^ 8'(k * 29);
            n = 3'(k + 5);
            l = ~1'(k);
            cyc(1'b1, fwd(x, n, l), n, l, x, 1'b0, acc);
            if (acc) k++;
        end
        chk("fill_accepts", k, 3);
        chk("full_in_ready", 32'(bus.in_ready), 0);
        chk("full_out_valid", 32'(bus.out_valid), 1);
        chk("full_busy", 32'(busy), 1);
        chk("full_out", 32'(bus.Out), 32'(exp_q[0]));
        repeat (3) cyc(1'b1, 8'h00, 3'd0, 1'b0, 8'h00, 1'b0, acc);
        chk("held_out", 32'(bus.Out), 32'(exp_q[0]));
        chk("held_out_lr", 32'(bus.out_lr), 32'(lr_q[0]));
        for (int i = 0; i < 60 && n_out < base + 6; i++) begin
            x = 8'hC3 ^ 8'(k * 29);
            n = 3'(k + 5);
            l = ~1'(k);
            cyc(k < 6, fwd(x, n, l), n, l, x, 1'(i), acc);
            if (acc) k++;
        end
        chk("toggle_count", n_out - base, 6);
        chk("toggle_queue", exp_q.size(), 0);
        k = 0;
        did_rst = 0;
        x = 8'($urandom);
        n = 3'($urandom);
        l = 1'($urandom);
        for (int c = 0; c < 8000 && k < 1000; c++) begin
            if (k >= 500 && !did_rst && bus.out_valid) begin
                rst_n = 1'b0;
                #1;
                chk("midrst_out_valid", 32'(bus.out_valid), 0);
                chk("midrst_busy", 32'(busy), 0);
                chk("midrst_out", 32'(bus.Out), 0);
                exp_q.delete();
                lr_q.delete();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                did_rst = 1;
                #1;
                chk("rel_in_ready", 32'(bus.in_ready), 1);
                chk("rel_out_valid", 32'(bus.out_valid), 0);
            end
            cyc($urandom_range(0, 3) != 0, fwd(x, n, l), n, l, x, $urandom_range(0, 3) != 0, acc);
            if (acc) begin
                k++;
                x = 8'($urandom);
                n = 3'($urandom);
                l = 1'($urandom);
            end
        end
        chk("rand_accepts", k, 1000);
        chk("rand_reset_hit", 32'(did_rst), 1);
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) cyc(1'b0, 8'h00, 3'd0, 1'b0, 8'h00, 1'b1, acc);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_busy", 32'(busy), 0);
        chk("drain_out_valid", 32'(bus.out_valid), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
